// File: rtl/ram_stream_reader.sv
// Streams a burst of words out of a synchronous-read RAM onto a valid/ready
// interface. A 2-entry FIFO absorbs the one-cycle RAM latency under backpressure.
module ram_stream_reader #(
  parameter int RAM_WIDTH = 8,
  parameter int ADDR_SIZE = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_SIZE-1:0] base_add,
  input  logic [ADDR_SIZE:0]   length,
  input  logic                 abort,
  output logic                 rd_en,
  output logic [ADDR_SIZE-1:0] rd_add,
  input  logic [RAM_WIDTH-1:0] ram_data,
  output logic [RAM_WIDTH-1:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 m_last,
  output logic                 busy,
  output logic                 done
);
  localparam int CW = ADDR_SIZE + 1;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, FINISH} state_t;
  state_t state, state_nxt;

  logic [ADDR_SIZE-1:0] base_q;
  logic [CW-1:0]        len_q, issued, xfered;
  logic                 in_flight;
  logic [RAM_WIDTH-1:0] fifo [2];
  logic                 wr_ptr, rd_ptr;
  logic [1:0]           count, occ;
  logic                 xfer, flush, accept;

  assign occ     = count + {1'b0, in_flight};
  assign m_valid = (count != 2'd0);
  assign xfer    = m_valid && m_ready;
  assign m_data  = m_valid ? fifo[rd_ptr] : '0;
  // Extra bit keeps xfered+1 from wrapping before the compare.
  assign m_last  = m_valid &&
                   (({1'b0, xfered} + {{CW{1'b0}}, 1'b1}) == {1'b0, len_q});
  assign rd_add  = rd_en ? (base_q + issued[ADDR_SIZE-1:0]) : '0;
  assign flush   = abort && (state == READ || state == DRAIN);
  assign accept  = (state == IDLE) && start && !abort;

  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    busy      = (state != IDLE);
    done      = (state == FINISH);
    case (state)
      IDLE:
        if (accept) state_nxt = (length == '0) ? FINISH : READ;
      READ:
        if (abort) state_nxt = IDLE;
        else if ((issued < len_q) &&
                 (occ <= 2'd1 || (occ == 2'd2 && xfer))) begin
          rd_en = 1'b1;
          if ((issued + CW'(1)) == len_q) state_nxt = DRAIN;
        end
      DRAIN:
        if (abort) state_nxt = IDLE;
        else if (xfer && m_last) state_nxt = FINISH;
      FINISH:
        state_nxt = IDLE;
      default:
        state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      base_q    <= '0;
      len_q     <= '0;
      issued    <= '0;
      xfered    <= '0;
      in_flight <= 1'b0;
      fifo[0]   <= '0;
      fifo[1]   <= '0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      count     <= 2'd0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        base_q <= base_add;
        len_q  <= length;
        issued <= '0;
        xfered <= '0;
      end
      if (rd_en) issued <= issued + CW'(1);
      if (xfer)  xfered <= xfered + CW'(1);
      if (flush) begin
        in_flight <= 1'b0;
        count     <= 2'd0;
        wr_ptr    <= 1'b0;
        rd_ptr    <= 1'b0;
      end else begin
        // RAM data lands one cycle after its read was issued.
        in_flight <= rd_en;
        if (in_flight) begin
          fifo[wr_ptr] <= ram_data;
          wr_ptr       <= ~wr_ptr;
        end
        if (xfer) rd_ptr <= ~rd_ptr;
        count <= count + {1'b0, in_flight} - {1'b0, xfer};
      end
    end
  end
endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed bench for ram_stream_reader with a behavioural RAM holding mem[i] = i[7:0].
module tb_ram_stream_reader;
  logic       clk = 1'b0;
  logic       rst, start, abort, m_ready;
  logic [9:0] base_add;
  logic [10:0] length;
  logic       rd_en, m_valid, m_last, busy, done;
  logic [9:0] rd_add;
  logic [7:0] ram_data, m_data;
  int vectors = 0, miscompares = 0;

  ram_stream_reader #(.RAM_WIDTH(8), .ADDR_SIZE(10)) dut (
    .clk(clk), .rst(rst), .start(start), .base_add(base_add), .length(length),
    .abort(abort), .rd_en(rd_en), .rd_add(rd_add), .ram_data(ram_data),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .busy(busy), .done(done));

  always #5 clk = ~clk;

  always @(posedge clk) if (rd_en) ram_data <= rd_add[7:0];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Burst with m_ready held high; cycle i relative to the start cycle.
  task automatic run_burst(input logic [9:0] base, input int len);
    logic [9:0] a;
    for (int i = 0; i <= len + 4; i++) begin
      start    = (i == 0);
      base_add = base;
      length   = 11'(len);
      m_ready  = 1'b1;
      #1;
      check("rd_en", 32'(rd_en), 32'(i >= 1 && i <= len));
      if (rd_en) begin
        a = base + 10'(i - 1);
        check("rd_add", 32'(rd_add), 32'(a));
      end
      check("m_valid", 32'(m_valid), 32'(i >= 3 && i <= len + 2));
      if (m_valid) begin
        a = base + 10'(i - 3);
        check("m_data", 32'(m_data), 32'(a[7:0]));
        check("m_last", 32'(m_last), 32'(i == len + 2));
      end
      check("done", 32'(done), 32'(i == len + 3));
      check("busy", 32'(busy), 32'(i >= 1 && i <= len + 3));
      tick();
    end
    start = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_rd_en"}, 32'(rd_en), 0);
    check({tag, "_rd_add"}, 32'(rd_add), 0);
    check({tag, "_m_data"}, 32'(m_data), 0);
    check({tag, "_m_valid"}, 32'(m_valid), 0);
    check({tag, "_m_last"}, 32'(m_last), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
  endtask

  initial begin
    int words, issued_n, xfer_n;
    logic [7:0] held;
    logic stalled, seen_done;

    rst = 1'b1; start = 1'b0; abort = 1'b0; m_ready = 1'b0;
    base_add = '0; length = '0;
    #1;
    check_zero("reset");
    tick(); tick();
    rst = 1'b0;

    run_burst(10'h010, 4);
    run_burst(10'h3FE, 4);

    // Length 8 with alternating backpressure.
    words = 0; issued_n = 0; xfer_n = 0; stalled = 1'b0; held = '0; seen_done = 1'b0;
    for (int c = 0; c < 60 && !seen_done; c++) begin
      start = (c == 0); base_add = 10'h100; length = 11'd8;
      m_ready = c[0];
      #1;
      check("occ_max", 32'(issued_n - xfer_n <= 2), 1);
      if (stalled) check("stall_hold", 32'(m_data), 32'(held));
      if (m_valid && m_ready) begin
        check("bp_data", 32'(m_data), 32'(words));
        check("bp_last", 32'(m_last), 32'(words == 7));
        words++;
      end
      if (rd_en) issued_n++;
      if (m_valid && m_ready) xfer_n++;
      stalled = m_valid && !m_ready;
      held = m_data;
      seen_done = done;
      tick();
    end
    start = 1'b0;
    check("bp_words", 32'(words), 8);
    check("bp_done_seen", 32'(seen_done), 1);
    tick();

    // Zero-length burst.
    start = 1'b1; base_add = 10'h055; length = 11'd0; m_ready = 1'b1;
    #1;
    check("z0_busy", 32'(busy), 0);
    tick(); start = 1'b0; #1;
    check("z1_done", 32'(done), 1);
    check("z1_busy", 32'(busy), 1);
    check("z1_rd_en", 32'(rd_en), 0);
    tick(); #1;
    check("z2_done", 32'(done), 0);
    check("z2_busy", 32'(busy), 0);
    check("z2_rd_en", 32'(rd_en), 0);
    tick();

    // Abort after three transfers of a length-10 burst.
    words = 0;
    for (int i = 0; i <= 5; i++) begin
      start = (i == 0); base_add = 10'h020; length = 11'd10; m_ready = 1'b1;
      #1;
      if (m_valid) begin
        check("ab_data", 32'(m_data), 32'(8'h20 + 8'(words)));
        words++;
      end
      tick();
    end
    start = 1'b0;
    check("ab_words", 32'(words), 3);
    abort = 1'b1;
    tick(); abort = 1'b0; #1;
    check("ab_m_valid", 32'(m_valid), 0);
    check("ab_busy", 32'(busy), 0);
    for (int i = 0; i < 3; i++) begin
      check("ab_no_done", 32'(done), 0);
      tick(); #1;
    end
    tick();
    run_burst(10'h030, 3);

    // Reset between edges mid-burst.
    for (int i = 0; i < 4; i++) begin
      start = (i == 0); base_add = 10'h050; length = 11'd6; m_ready = 1'b1;
      tick();
    end
    start = 1'b0;
    #1;
    check("pre_rst_valid", 32'(m_valid), 1);
    rst = 1'b1;
    #1;
    check_zero("midrst");
    tick(); tick();
    rst = 1'b0;
    run_burst(10'h010, 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/ram_stream_reader.md
RAM_STREAM_READER -- requirements
Module: ram_stream_reader

Interface
REQ-001 Parameter RAM_WIDTH, default 8, shall set the data word width in bits.
REQ-002 Parameter ADDR_SIZE, default 10, shall set the RAM address width; address space 2^ADDR_SIZE words.
REQ-003 clk  input  1  shall be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  shall be the reset: asynchronous, active-high.
REQ-005 start  input  1  shall request a burst; sampled only in IDLE.
REQ-006 base_add  input  ADDR_SIZE  shall give the first read address; sampled with start.
REQ-007 length  input  ADDR_SIZE+1  shall give the word count, 0..2^(ADDR_SIZE+1)-1; sampled with start.
REQ-008 abort  input  1  shall be a synchronous burst cancel request.
REQ-009 rd_en  output  1  shall be the read enable driven to the RAM.
REQ-010 rd_add  output  ADDR_SIZE  shall be the read address driven to the RAM.
REQ-011 ram_data  input  RAM_WIDTH  shall carry RAM read data, valid in the cycle after rd_en.
REQ-012 m_data  output  RAM_WIDTH  shall be the output stream data.
REQ-013 m_valid  output  1  shall mark m_data valid.
REQ-014 m_ready  input  1  shall be sink acceptance; transfer occurs when m_valid and m_ready are both high.
REQ-015 m_last  output  1  shall mark the final word of a burst; qualified by m_valid.
REQ-016 busy  output  1  shall be high in every state except IDLE.
REQ-017 done  output  1  shall pulse for one cycle when a burst completes normally.

Function
REQ-018 FSM states shall be IDLE, READ, DRAIN and FINISH.
- IDLE -> READ on start with length != 0.
- IDLE -> FINISH on start with length == 0.
REQ-019 In READ, the nth issued read (n = 0..length-1) shall use rd_add = (base_add + n) mod 2^ADDR_SIZE; wrap past the top address is legal, and length > 2^ADDR_SIZE repeats addresses.
REQ-020 Output buffering: 2-entry FIFO; occ = FIFO count + in-flight reads (0 or 1).
REQ-021 rd_en shall be high in READ while issued < length and either occ <= 1, or occ == 2 with a transfer occurring in the same cycle.
REQ-022 A read issued in cycle t shall write ram_data into the FIFO at the end of cycle t+1; the FIFO shall never overflow and no RAM data shall be dropped.
REQ-023 m_valid shall be high whenever the FIFO is non-empty; m_data shall show the FIFO head; m_data and m_valid shall be held stable while m_valid is high and m_ready is low.
REQ-024 Latency: with start in cycle t and m_ready held high, rd_en shall first rise in t+1 and m_valid in t+3; words shall then stream at 1 per cycle.
REQ-025 READ -> DRAIN after the last read issues; DRAIN -> FINISH on the transfer carrying m_last.
REQ-026 FINISH shall last one cycle, with done = 1, then return to IDLE; busy shall be high in FINISH.
REQ-027 start shall be ignored outside IDLE; start and abort together in IDLE shall be ignored.
REQ-028 On abort in READ or DRAIN:
- issuing shall stop that cycle;
- the FIFO and the in-flight read shall be discarded;
- the state shall be IDLE next cycle with m_valid = 0;
- no done pulse shall occur.
REQ-029 The issue counter and transfer counter shall be ADDR_SIZE+1 bits and shall not overflow for any legal length.

Reset
REQ-030 While rst is high, the block shall be in IDLE, with the FIFO empty, counters 0 and no read in flight.
REQ-031 While rst is high, rd_en, rd_add, m_data, m_valid, m_last, busy and done shall all be 0.
REQ-032 rst asserted mid-burst shall take effect immediately without waiting for a clock edge; the first start after release shall begin a clean burst.

Verification
REQ-033 RAM preloaded mem[i] = i; base 0x010, length 4, m_ready = 1 -> rd_add 0x010..0x013 on consecutive cycles; m_data 0x10..0x13; m_last on 0x13; done one cycle after that.
REQ-034 base 0x3FE, length 4 -> rd_add 0x3FE, 0x3FF, 0x000, 0x001; data in the same order.
REQ-035 length 8 with m_ready toggling 1/0 each cycle -> all 8 words delivered in order; occ never exceeds 2; m_data stable while stalled.
REQ-036 length 0 -> no rd_en; done in t+1; busy high for exactly one cycle.
REQ-037 abort after 3 transfers of a length 10 burst -> m_valid = 0 and busy = 0 next cycle; no done; a following burst returns correct data.
REQ-038 rst asserted mid-burst between clock edges -> all outputs 0 immediately; start after release behaves as in REQ-033.
